// File: rtl/fetch_queue_unit_pkg.sv
// fetch_queue_unit_pkg
// Shared definitions for the instruction fetch front end: datapath width,
// the HALT opcode, the fetch FSM state type, the queue entry layout and a
// helper that classifies an instruction word as HALT.
// Optional feature macro: FETCH_HALT_STOP_EN (adds the HALTED state).

package fetch_queue_unit_pkg;

  localparam int XLEN = 16;
  localparam logic [4:0] OP_HALT = 5'b00000;

`ifdef FETCH_HALT_STOP_EN
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1
  } fetch_state_e;
`endif

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fq_entry_t;

  // Opcode lives in the top five bits of the instruction word.
  function automatic logic is_halt(input logic [XLEN-1:0] instr);
    return instr[XLEN-1:XLEN-5] == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// fetch_fifo
// Circular buffer of {instr, pc} entries feeding the decoder.
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   flush_i         empties the buffer; overrides push/pop this cycle
//   push_i, data_i  enqueue an entry (accepted when not full, or full with pop)
//   pop_i           dequeue the head (ignored when empty)
//   head_o          head entry (meaningful only while count_o != 0)
//   count_o         current occupancy, 0..DEPTH

module fetch_fifo
  import fetch_queue_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  fq_entry_t                  data_i,
  input  logic                       pop_i,
  output fq_entry_t                  head_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fq_entry_t     mem_q [DEPTH];
  logic [AW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic          do_push_s, do_pop_s;

  // A full buffer can still take a push when the head leaves in the same cycle.
  assign do_pop_s  = pop_i & (count_q != {CW{1'b0}});
  assign do_push_s = push_i & ((count_q != CW'(DEPTH)) | do_pop_s);

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= {AW{1'b0}};
      tail_q  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
    end else if (flush_i) begin
      head_q  <= {AW{1'b0}};
      tail_q  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      if (do_pop_s)  head_q <= head_q + AW'(1);
      if (do_push_s) tail_q <= tail_q + AW'(1);
      count_q <= count_q + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  // Entry storage; contents are don't-care while the slot is not occupied.
  always_ff @(posedge clk_i) begin
    if (do_push_s && !flush_i) mem_q[tail_q] <= data_i;
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
// Instruction fetch front end: owns the PC, keeps at most one request to
// instruction memory in flight, buffers returned words in fetch_fifo and
// presents them to decode with a valid/ready handshake. Redirects flush the
// buffer and make any in-flight response stale via a one-bit epoch.
// Optional feature macro: FETCH_HALT_STOP_EN -- when defined, a pushed word
// with opcode OP_HALT stops fetching until the next redirect.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   imem_req/imem_addr           request strobe and word-aligned address
//   imem_valid/imem_data         response strobe and instruction word
//   redirect/redirect_pc         taken control transfer from execute
//   dec_valid/dec_instr/dec_pc   head instruction and its address
//   dec_pc2                      dec_pc + 2 (link value)
//   dec_ready                    decode consumes the head this cycle
//   halted                       fetch stopped on HALT

module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [15:0] imem_data,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        dec_valid,
  output logic [15:0] dec_instr,
  output logic [15:0] dec_pc,
  output logic [15:0] dec_pc2,
  input  logic        dec_ready,
  output logic        halted
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] out_addr_q, out_addr_d;
  logic            epoch_q, epoch_d;
  logic            out_epoch_q, out_epoch_d;

  logic [CW-1:0]   count_s, count_after_s;
  fq_entry_t       head_s, push_entry_s;
  logic            resp_s, fresh_s, push_s, pop_s, halt_hit_s, issue_s;

  // A response only counts while a request is outstanding; it is fresh when
  // its tag still matches the current epoch.
  assign resp_s        = (state_q == WAIT) & imem_valid;
  assign fresh_s       = resp_s & (out_epoch_q == epoch_q);
  assign push_s        = fresh_s & ~redirect;
  assign pop_s         = dec_valid & dec_ready & ~redirect;
  assign count_after_s = count_s + CW'(push_s) - CW'(pop_s);
  assign push_entry_s  = '{instr: imem_data, pc: out_addr_q};

`ifdef FETCH_HALT_STOP_EN
  assign halt_hit_s = push_s & is_halt(imem_data);
`else
  assign halt_hit_s = 1'b0;
`endif

  // Request issue: from RUN when there is room, or back-to-back with a fresh
  // response when the buffer will still have room after this cycle.
  always_comb begin
    issue_s = 1'b0;
    if (rst || redirect) begin
      issue_s = 1'b0;
    end else if (state_q == RUN) begin
      issue_s = (count_s < CW'(DEPTH));
    end else if (state_q == WAIT) begin
      issue_s = fresh_s & ~halt_hit_s & (count_after_s < CW'(DEPTH));
    end else begin
      issue_s = 1'b0;
    end
  end

  // Next-state logic for the fetch FSM, PC and epoch bookkeeping.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    epoch_d     = epoch_q;
    out_epoch_d = out_epoch_q;
    out_addr_d  = out_addr_q;
    if (redirect) begin
      pc_d        = redirect_pc & 16'hFFFE;
      epoch_d     = ~epoch_q;
      // Pin the outstanding tag to the old epoch so it stays stale even if
      // several redirects arrive before the response does.
      out_epoch_d = epoch_q;
      state_d     = ((state_q == WAIT) && !imem_valid) ? WAIT : RUN;
    end else if (issue_s) begin
      pc_d        = pc_q + 16'd2;
      out_addr_d  = pc_q;
      out_epoch_d = epoch_q;
      state_d     = WAIT;
    end else if (resp_s) begin
`ifdef FETCH_HALT_STOP_EN
      state_d = halt_hit_s ? HALTED : RUN;
`else
      state_d = RUN;
`endif
    end else begin
      state_d = state_q;
    end
  end

  // FSM, PC and epoch registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      out_addr_q  <= 16'h0000;
      epoch_q     <= 1'b0;
      out_epoch_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_addr_q  <= out_addr_d;
      epoch_q     <= epoch_d;
      out_epoch_q <= out_epoch_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (redirect),
    .push_i  (push_s),
    .data_i  (push_entry_s),
    .pop_i   (pop_s),
    .head_o  (head_s),
    .count_o (count_s)
  );

  assign imem_req  = issue_s;
  assign imem_addr = issue_s ? pc_q : 16'h0000;
  assign dec_valid = (count_s != {CW{1'b0}});
  assign dec_instr = dec_valid ? head_s.instr : 16'h0000;
  assign dec_pc    = dec_valid ? head_s.pc : 16'h0000;
  assign dec_pc2   = dec_valid ? (head_s.pc + 16'd2) : 16'h0000;

`ifdef FETCH_HALT_STOP_EN
  assign halted = (state_q == HALTED);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit
// Self-checking bench for fetch_queue_unit: a behavioural memory with
// variable latency, a transaction-level reference model (expected PC stream,
// queue of expected decode entries, outstanding/stale request tracking) and
// directed scenarios followed by randomized traffic.
// Honours FETCH_HALT_STOP_EN the same way the design does.

module tb_fetch_queue_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        dec_valid;
  logic [15:0] dec_instr;
  logic [15:0] dec_pc;
  logic [15:0] dec_pc2;
  logic        dec_ready;
  logic        halted;

  always #5 clk = ~clk;

  fetch_queue_unit #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dec_valid   (dec_valid),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc),
    .dec_pc2     (dec_pc2),
    .dec_ready   (dec_ready),
    .halted      (halted)
  );

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
  } ent_t;

  // reference model state
  ent_t        m_q[$];
  logic [15:0] m_pc, m_out_addr;
  bit          m_out, m_stale, m_halted;

  // memory model and knobs
  bit          pend;
  logic [15:0] pend_addr;
  int          pend_due;
  int          cyc;
  int          lat_max, ready_pct;
  bit          lat_rand, spur_en, redir_en, force_rd;
  logic [15:0] force_pc, halt_addr;

  // observation
  int          n_req, n_pop;
  bit          req_now;
  logic [15:0] last_req, last_pop_pc;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] w;
    if (a == halt_addr) w = 16'h0000;
    else                w = 16'h4000 + a;
    return w;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc     = 16'h0000;
    m_out    = 1'b0;
    m_stale  = 1'b0;
    m_halted = 1'b0;
    pend     = 1'b0;
  endtask

  // One clock cycle: drive inputs at a falling edge, predict, compare, update.
  task automatic step();
    logic        v, rd, rdy, fresh, pop, push, halt_hit, exp_req;
    logic [15:0] d, rpc;
    int          sz, occ;
    ent_t        e;
    v = 1'b0; d = 16'h0000; rd = 1'b0; rpc = 16'h0000;
    if (pend && pend_due <= cyc) begin
      v = 1'b1; d = mem_word(pend_addr); pend = 1'b0;
    end else if (!pend && spur_en && $urandom_range(15) == 0) begin
      v = 1'b1; d = 16'($urandom);
    end
    if (force_rd) begin
      rd = 1'b1; rpc = force_pc; force_rd = 1'b0;
    end else if (redir_en && $urandom_range(23) == 0) begin
      rd = 1'b1; rpc = 16'($urandom_range(255));
    end
    rdy = ($urandom_range(99) < ready_pct);
    imem_valid = v; imem_data = d; redirect = rd; redirect_pc = rpc; dec_ready = rdy;
    #1;
    sz       = m_q.size();
    fresh    = v && m_out && !m_stale;
    pop      = rdy && (sz > 0) && !rd;
    push     = fresh && !rd;
    halt_hit = 1'b0;
`ifdef FETCH_HALT_STOP_EN
    halt_hit = push && (d[15:11] == 5'b00000);
`endif
    occ      = sz + (push ? 1 : 0) - (pop ? 1 : 0);
    exp_req  = !rd && ((!m_out && !m_halted && sz < DEPTH) ||
                       (fresh && !halt_hit && occ < DEPTH));
    chk("dec_valid", dec_valid, (sz > 0));
    if (sz > 0) begin
      chk("dec_instr", dec_instr, m_q[0].instr);
      chk("dec_pc", dec_pc, m_q[0].pc);
      chk("dec_pc2", dec_pc2, 16'(m_q[0].pc + 16'd2));
    end
    chk("halted", halted, m_halted);
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    // memory and observation bookkeeping from what the DUT actually did
    req_now = imem_req;
    if (imem_req) begin
      pend      = 1'b1;
      pend_addr = imem_addr;
      pend_due  = cyc + 1 + (lat_rand ? int'($urandom_range(lat_max)) : lat_max);
      n_req++;
      last_req  = imem_addr;
    end
    if (dec_valid && rdy && !rd) begin
      n_pop++;
      last_pop_pc = dec_pc;
    end
    // model update
    if (rd) begin
      m_q.delete();
      m_pc     = rpc & 16'hFFFE;
      m_halted = 1'b0;
      if (m_out && !v) m_stale = 1'b1;
      else             m_out   = 1'b0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        e.instr = d; e.pc = m_out_addr;
        m_q.push_back(e);
      end
      if (halt_hit) m_halted = 1'b1;
      if (v && m_out) begin m_out = 1'b0; m_stale = 1'b0; end
      if (exp_req) begin
        m_out = 1'b1; m_stale = 1'b0; m_out_addr = m_pc; m_pc = m_pc + 16'd2;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  // Assert reset (asynchronously), check outputs are zero at once, hold n cycles.
  task automatic apply_reset(input int n);
    rst = 1'b1; imem_valid = 1'b0; redirect = 1'b0; dec_ready = 1'b0;
    #1;
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_imem_addr", imem_addr, 16'h0000);
    chk("rst_dec_valid", dec_valid, 1'b0);
    chk("rst_dec_instr", dec_instr, 16'h0000);
    chk("rst_dec_pc", dec_pc, 16'h0000);
    chk("rst_dec_pc2", dec_pc2, 16'h0000);
    chk("rst_halted", halted, 1'b0);
    for (int k = 0; k < n; k++) begin
      // a response to a request cut off by reset arrives while reset is held
      if (pend) begin
        imem_valid = 1'b1; imem_data = mem_word(pend_addr); pend = 1'b0;
      end else begin
        imem_valid = 1'b0;
      end
      @(negedge clk);
    end
    imem_valid = 1'b0;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_req(input logic [15:0] a, input string tag);
    bit found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      step();
      found = req_now && (last_req == a);
    end
    chk(tag, found, 1'b1);
  endtask

  task automatic next_req(input logic [15:0] a, input string tag);
    bit found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      step();
      found = req_now;
    end
    chk({tag, "_seen"}, found, 1'b1);
    chk(tag, last_req, a);
  endtask

  initial begin
    int  r0, p0;
    bit  got;
    rst = 1'b1; imem_valid = 1'b0; imem_data = 16'h0000;
    redirect = 1'b0; redirect_pc = 16'h0000; dec_ready = 1'b0;
    cyc = 0; n_req = 0; n_pop = 0; req_now = 1'b0;
    last_req = 16'h0000; last_pop_pc = 16'h0000;
    lat_max = 0; lat_rand = 1'b0; spur_en = 1'b0; redir_en = 1'b0;
    force_rd = 1'b0; force_pc = 16'h0000; ready_pct = 100; halt_addr = 16'hFFFF;
    model_reset();
    @(negedge clk);

    // sequential stream with single-cycle memory
    apply_reset(2);
    next_req(16'h0000, "first_req");
    repeat (3) step();
    p0 = n_pop;
    repeat (16) step();
    chk("sustained_rate", n_pop - p0, 16);

    // back-pressure: buffer fills, fetch stops, then resumes in order
    apply_reset(2);
    ready_pct = 0;
    r0 = n_req;
    repeat (10) step();
    chk("fill_reqs", n_req - r0, DEPTH);
    chk("full_valid", dec_valid, 1'b1);
    ready_pct = 100;
    next_req(16'h0008, "resume_addr");
    repeat (6) step();

    // redirect while a request is outstanding: late response is dropped
    apply_reset(2);
    lat_max = 3;
    wait_req(16'h0006, "req_0006");
    force_rd = 1'b1; force_pc = 16'h0121;
    step();
    chk("flush_empty", dec_valid, 1'b0);
    p0 = n_pop; got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      step();
      got = (n_pop != p0);
    end
    chk("redir_pop_seen", got, 1'b1);
    chk("redir_first_pc", last_pop_pc, 16'h0120);

    // HALT word at 0004
    lat_max = 0; halt_addr = 16'h0004;
    apply_reset(2);
    ready_pct = 0;
    r0 = n_req;
    repeat (12) step();
`ifdef FETCH_HALT_STOP_EN
    chk("halt_reqs", n_req - r0, 3);
    chk("halt_flag", halted, 1'b1);
    ready_pct = 100;
    repeat (6) step();
    chk("halt_drained", dec_valid, 1'b0);
    chk("halt_no_req", n_req - r0, 3);
`else
    chk("nohalt_reqs", n_req - r0, DEPTH);
    chk("nohalt_flag", halted, 1'b0);
    ready_pct = 100;
    repeat (6) step();
    chk("nohalt_continues", (n_req - r0) > DEPTH, 1'b1);
`endif
    force_rd = 1'b1; force_pc = 16'h0040;
    step();
    chk("halt_cleared", halted, 1'b0);
    next_req(16'h0040, "halt_resume");
    halt_addr = 16'hFFFF;
    repeat (4) step();

    // PC wrap FFFE -> 0000
    force_rd = 1'b1; force_pc = 16'hFFFC;
    step();
    wait_req(16'hFFFE, "req_fffe");
    next_req(16'h0000, "pc_wrap");
    repeat (4) step();

    // reset in the middle of an outstanding request
    lat_max = 3;
    apply_reset(2);
    step();
    step();
    apply_reset(3);
    next_req(16'h0000, "post_rst_req");
    repeat (8) step();

    // randomized traffic
    apply_reset(2);
    lat_rand = 1'b1; lat_max = 3; spur_en = 1'b1; redir_en = 1'b1;
    ready_pct = 70; halt_addr = 16'h0010;
    repeat (1500) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
# fetch_queue_unit

Instruction fetch front end that produces the 16-bit instruction stream consumed by the control decoder. It owns the PC, issues single-outstanding requests to instruction memory, buffers returned words in a small FIFO, and presents them to decode with a valid/ready handshake. Branch and jump redirects from execute flush the buffer and discard in-flight responses. A HALT opcode stops further fetching.

## Interface
- DEPTH, 4, FIFO entries; power of two, minimum 2
- RESET_PC, 16'h0000, PC loaded on reset
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  request strobe, one cycle per request
- imem_addr  out  16  word-aligned byte address; valid while imem_req=1
- imem_valid  in  1  response strobe, one cycle
- imem_data  in  16  instruction word; valid with imem_valid
- redirect  in  1  taken branch/jump/JR/JALR/RTI from execute
- redirect_pc  in  16  new PC; bit 0 ignored (forced 0)
- dec_valid  out  1  head entry is valid
- dec_instr  out  16  head instruction; opcode is dec_instr[15:11]
- dec_pc  out  16  address of head instruction
- dec_pc2  out  16  dec_pc + 2, for JAL/JALR/SIIC link
- dec_ready  in  1  decode accepts head this cycle
- halted  out  1  fetch stopped after HALT

## Operation
- Reset: PC=RESET_PC; FIFO empty; no request outstanding; imem_req=0, dec_valid=0, halted=0, epoch=0. All data outputs 0.
- States: RUN, WAIT (one request outstanding), HALTED.
- RUN: when count + 0 < DEPTH, assert imem_req with imem_addr=PC, PC+=2 (16-bit wrap, FFFE -> 0000), go WAIT.
- WAIT: on imem_valid with tag epoch == current epoch, push {imem_data, addr}. Same cycle, a new request may issue if count after push/pop < DEPTH; otherwise return to RUN. Stale responses (epoch mismatch) are dropped without push.
- Pop: dec_valid & dec_ready removes head. Push and pop in the same cycle are legal at any occupancy, including full (net count unchanged).
- Redirect: highest priority. Flush FIFO (count=0), PC=redirect_pc, toggle epoch, leave HALTED, go RUN if no request outstanding, else WAIT-stale (response still absorbed, then RUN). Same-cycle push and pop are both cancelled.
- HALT: pushed word with [15:11]=5'b00000 enters HALTED after push (see Configuration). No new requests; FIFO drains normally; halted=1.
- Only redirect or rst leaves HALTED.
- Memory protocol: at most one outstanding request; imem_valid without outstanding request is ignored.

## Timing
- rst deassert at edge N: first imem_req at cycle N+1 (combinational from state RUN).
- imem_valid at cycle T: dec_valid=1 at T+1 if FIFO was empty (registered; no bypass).
- With single-cycle memory and dec_ready=1: sustained one instruction per cycle.
- redirect at cycle R: dec_valid=0 at R+1; imem_req to redirect_pc at R+1 if nothing outstanding, else cycle after stale response.
- halted rises the cycle after the HALT word is pushed.

## Configuration
- FETCH_HALT_STOP_EN defined: HALT detection as above.
- Undefined: opcode not inspected; fetch continues sequentially past HALT; halted tied 0; HALTED state absent.

## Structure
- Shared package: opcode constant OP_HALT=5'b00000, fetch state enum {RUN, WAIT, HALTED}, instruction/PC width 16.
- Sub-module fetch_fifo: circular buffer of {instr, pc}, DEPTH entries, head/tail pointers log2(DEPTH) bits plus count, flush input; parent owns PC, epoch and FSM.

## Test plan
- Reset then 1-cycle memory returning 16'h4000+addr, dec_ready=1 -> imem_addr 0000,0002,0004...; dec_pc matches, one dec_valid per cycle, dec_pc2=dec_pc+2.
- dec_ready=0, DEPTH=4 -> exactly 4 pushes then imem_req stays 0; raise dec_ready -> order preserved, fetch resumes at 0008.
- Request to 0006 outstanding, redirect to 0x0120 -> late response dropped, next dec_pc=0120, FIFO empty at R+1.
- Memory word 16'h0000 at 0004 with FETCH_HALT_STOP_EN -> no request after 0004, halted=1, queued words drain; redirect to 0x0040 resumes fetch, halted=0.
- Same test without macro -> fetch continues to 0006, halted=0.
- PC=FFFE -> next imem_addr 0000; rst asserted mid-WAIT -> outputs zero immediately, following response ignored.
